// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, datapath select encodings and the decode class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_SH2  = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction classifier: maps the IR contents to a one-hot instruction class.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    // Anything not recognised, the all-zero word included, retires as a nop.
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls.addu = 1'b1;
                    FN_SUB:  cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: cls.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: state register, next-state logic, combinational
// output decoder and retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic [1:0]       npc_op,
    output logic [1:0]       eop,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             dm_req,
    output logic             dm_wr,
    output logic             instr_done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    cls_t             cls;
    logic [1:0]       ex_eop;
    logic [2:0]       ex_alu;
    logic             ex_srcb;

    mc_ctrl_decode u_dec (
        .instr (instr),
        .cls   (cls)
    );

    // Extender/ALU selects used in EXE and held through WB.
    always_comb begin
        ex_eop  = EXT_SIGN;
        ex_alu  = ALU_ADD;
        ex_srcb = 1'b0;
        if (cls.subu) ex_alu = ALU_SUB;
        if (cls.ori) begin
            ex_eop  = EXT_ZERO;
            ex_alu  = ALU_OR;
            ex_srcb = 1'b1;
        end
        if (cls.lui) begin
            ex_eop  = EXT_LUI;
            ex_srcb = 1'b1;
        end
        if (cls.lw || cls.sw) ex_srcb = 1'b1;
        if (cls.beq) begin
            ex_eop = EXT_SH2;
            ex_alu = ALU_SUB;
        end
    end

    always_comb begin
        state_d    = ST_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        npc_op     = NPC_PC4;
        eop        = EXT_SIGN;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = DST_RT;
        wd_sel     = WD_ALU;
        dm_req     = 1'b0;
        dm_wr      = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.j || cls.jal) begin
                    pc_wr      = 1'b1;
                    npc_op     = NPC_J;
                    instr_done = 1'b1;
                    if (cls.jal) begin
                        reg_wr  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC;
                    end
                end else if (cls.jr) begin
                    pc_wr      = 1'b1;
                    npc_op     = NPC_JR;
                    instr_done = 1'b1;
                end else if (cls.nop) begin
                    instr_done = 1'b1;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                eop       = ex_eop;
                alu_op    = ex_alu;
                alu_src_b = ex_srcb;
                if (cls.beq) begin
                    npc_op     = NPC_BR;
                    pc_wr      = zero;
                    instr_done = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                dm_wr  = cls.sw;
                if (!dm_ready)   state_d = ST_MEM;
                else if (cls.lw) state_d = ST_WB;
                else             instr_done = 1'b1;
            end
            ST_WB: begin
                eop        = ex_eop;
                alu_op     = ex_alu;
                alu_src_b  = ex_srcb;
                reg_wr     = 1'b1;
                reg_dst    = (cls.addu || cls.subu) ? DST_RD : DST_RT;
                wd_sel     = cls.lw ? WD_DM : WD_ALU;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset wins over everything, including a write that was about to land.
        if (!reset) begin
            state_d    = ST_FETCH;
            pc_wr      = 1'b0;
            ir_wr      = 1'b0;
            npc_op     = NPC_PC4;
            eop        = EXT_SIGN;
            alu_op     = ALU_ADD;
            alu_src_b  = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = DST_RT;
            wd_sel     = WD_ALU;
            dm_req     = 1'b0;
            dm_wr      = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign retired_d = retired_q + CNT_W'(instr_done);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared on the following falling edge.
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        dm_ready;
    logic        pc_wr, ir_wr, alu_src_b, reg_wr, dm_req, dm_wr, instr_done;
    logic [1:0]  npc_op, eop, reg_dst, wd_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;
    logic [20:0] got_vec;

    typedef struct {
        string       tag;
        logic [20:0] vec;
        logic [31:0] ret;
    } sb_t;

    sb_t         sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_ret = '0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .dm_ready   (dm_ready),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .npc_op     (npc_op),
        .eop        (eop),
        .alu_op     (alu_op),
        .alu_src_b  (alu_src_b),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .dm_req     (dm_req),
        .dm_wr      (dm_wr),
        .instr_done (instr_done),
        .state      (state),
        .retired    (retired)
    );

    assign got_vec = {state, pc_wr, ir_wr, npc_op, eop, alu_op, alu_src_b,
                      reg_wr, reg_dst, wd_sel, dm_req, dm_wr, instr_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output vector: state, pc_wr, ir_wr, npc_op, eop, alu_op,
    // alu_src_b, reg_wr, reg_dst, wd_sel, dm_req, dm_wr, instr_done.
    function automatic logic [20:0] ov(input int st, input int pc, input int ir,
                                       input int npc, input int eo, input int alu,
                                       input int sb, input int rw, input int rd,
                                       input int wd, input int rq, input int wr,
                                       input int dn);
        return {3'(st), 1'(pc), 1'(ir), 2'(npc), 2'(eo), 3'(alu), 1'(sb),
                1'(rw), 2'(rd), 2'(wd), 1'(rq), 1'(wr), 1'(dn)};
    endfunction

    // Called just after a rising edge: drive one cycle, check it at the falling edge.
    task automatic step(input string tag, input logic [31:0] ins, input int z,
                        input int rdy, input int rst, input logic [20:0] ev,
                        input bit do_chk);
        sb_t e;
        instr    = ins;
        zero     = 1'(z);
        dm_ready = 1'(rdy);
        reset    = 1'(rst);
        if (do_chk) begin
            e.tag = tag;
            e.vec = ev;
            e.ret = cur_ret;
            sbq.push_back(e);
        end
        if (rst != 0 && ev[0]) cur_ret++;
        if (rst == 0) cur_ret = '0;
        @(negedge clk);
        if (do_chk) begin
            if (sbq.size() == 0) begin
                chk({tag, "/sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk({e.tag, "/out"}, {11'b0, got_vec}, {11'b0, e.vec});
                chk({e.tag, "/ret"}, retired, e.ret);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] ins);
        step({tag, "/F"}, ins, 0, 0, 1, ov(0,1,1,0,0,0,0,0,0,0,0,0,0), 1);
    endtask

    task automatic dec(input string tag, input logic [31:0] ins, input logic [20:0] ev);
        step({tag, "/D"}, ins, 0, 0, 1, ev, 1);
    endtask

    localparam logic [20:0] D_IDLE = 21'(3'd1 << 18);

    initial begin
        reset = 1'b0; instr = '0; zero = 1'b0; dm_ready = 1'b0;
        @(posedge clk);
        #1;
        step("rst0", 32'h0, 0, 0, 0, '0, 0);
        step("rst1", 32'h0, 0, 0, 0, ov(0,0,0,0,0,0,0,0,0,0,0,0,0), 1);

        // ori
        fetch("ori", 32'h34221234);
        dec  ("ori", 32'h34221234, D_IDLE);
        step ("ori/E", 32'h34221234, 0, 0, 1, ov(2,0,0,0,1,2,1,0,0,0,0,0,0), 1);
        step ("ori/W", 32'h34221234, 0, 0, 1, ov(4,0,0,0,1,2,1,1,0,0,0,0,1), 1);

        // lw with three wait cycles
        fetch("lw", 32'h8C430004);
        dec  ("lw", 32'h8C430004, D_IDLE);
        step ("lw/E", 32'h8C430004, 0, 0, 1, ov(2,0,0,0,0,0,1,0,0,0,0,0,0), 1);
        for (int i = 0; i < 3; i++)
            step("lw/Mw", 32'h8C430004, 0, 0, 1, ov(3,0,0,0,0,0,0,0,0,0,1,0,0), 1);
        step ("lw/M", 32'h8C430004, 0, 1, 1, ov(3,0,0,0,0,0,0,0,0,0,1,0,0), 1);
        step ("lw/W", 32'h8C430004, 0, 0, 1, ov(4,0,0,0,0,0,1,1,0,1,0,0,1), 1);

        // beq taken and not taken
        fetch("beq1", 32'h1022FFFF);
        dec  ("beq1", 32'h1022FFFF, D_IDLE);
        step ("beq1/E", 32'h1022FFFF, 1, 0, 1, ov(2,1,0,1,3,1,0,0,0,0,0,0,1), 1);
        fetch("beq0", 32'h1022FFFF);
        dec  ("beq0", 32'h1022FFFF, D_IDLE);
        step ("beq0/E", 32'h1022FFFF, 0, 0, 1, ov(2,0,0,1,3,1,0,0,0,0,0,0,1), 1);

        // jumps and nops finish in DECODE
        fetch("jal", 32'h0C000100);
        dec  ("jal", 32'h0C000100, ov(1,1,0,2,0,0,0,1,2,2,0,0,1));
        fetch("j",   32'h08000100);
        dec  ("j",   32'h08000100, ov(1,1,0,2,0,0,0,0,0,0,0,0,1));
        fetch("jr",  32'h03E00008);
        dec  ("jr",  32'h03E00008, ov(1,1,0,3,0,0,0,0,0,0,0,0,1));
        fetch("nop", 32'h00000000);
        dec  ("nop", 32'h00000000, ov(1,0,0,0,0,0,0,0,0,0,0,0,1));
        fetch("ill", 32'hFC000000);
        dec  ("ill", 32'hFC000000, ov(1,0,0,0,0,0,0,0,0,0,0,0,1));

        // R-type add / sub
        fetch("add", 32'h00430820);
        dec  ("add", 32'h00430820, D_IDLE);
        step ("add/E", 32'h00430820, 0, 0, 1, ov(2,0,0,0,0,0,0,0,0,0,0,0,0), 1);
        step ("add/W", 32'h00430820, 0, 0, 1, ov(4,0,0,0,0,0,0,1,1,0,0,0,1), 1);
        fetch("sub", 32'h00430822);
        dec  ("sub", 32'h00430822, D_IDLE);
        step ("sub/E", 32'h00430822, 0, 0, 1, ov(2,0,0,0,0,1,0,0,0,0,0,0,0), 1);
        step ("sub/W", 32'h00430822, 0, 0, 1, ov(4,0,0,0,0,1,0,1,1,0,0,0,1), 1);

        // lui
        fetch("lui", 32'h3C011234);
        dec  ("lui", 32'h3C011234, D_IDLE);
        step ("lui/E", 32'h3C011234, 0, 0, 1, ov(2,0,0,0,2,0,1,0,0,0,0,0,0), 1);
        step ("lui/W", 32'h3C011234, 0, 0, 1, ov(4,0,0,0,2,0,1,1,0,0,0,0,1), 1);

        // sw with immediate ready
        fetch("sw", 32'hAC430008);
        dec  ("sw", 32'hAC430008, D_IDLE);
        step ("sw/E", 32'hAC430008, 0, 0, 1, ov(2,0,0,0,0,0,1,0,0,0,0,0,0), 1);
        step ("sw/M", 32'hAC430008, 0, 1, 1, ov(3,0,0,0,0,0,0,0,0,0,1,1,1), 1);

        // sw aborted by reset while waiting in MEM
        fetch("swr", 32'hAC430008);
        dec  ("swr", 32'hAC430008, D_IDLE);
        step ("swr/E", 32'hAC430008, 0, 0, 1, ov(2,0,0,0,0,0,1,0,0,0,0,0,0), 1);
        step ("swr/M", 32'hAC430008, 0, 0, 1, ov(3,0,0,0,0,0,0,0,0,0,1,1,0), 1);
        step ("swr/R", 32'hAC430008, 0, 1, 0, ov(3,0,0,0,0,0,0,0,0,0,0,0,0), 1);
        fetch("post", 32'h34221234);

        if (sbq.size() != 0) chk("sb_left", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
